// File: rtl/pack_polyvec_compress_ctrl.sv
// Kyber512 ciphertext polyvec compression sequencer.
// Reads four coefficients per memory word, compresses each to 10 bits with
// c = floor(((x << 10) + Q/2) / Q) mod 1024, packs four results into a 40-bit
// word and streams words through a small first-word-fall-through FIFO.

// Simulation-only protocol checker for the output FIFO and read credit.
module pack_polyvec_compress_ctrl_chk (
  input logic       clk_i,
  input logic       rst_n_i,
  input logic       push_i,
  input logic       full_i,
  input logic [1:0] inflight_i
);
  // A push into a full FIFO would lose a word; the read credit must prevent it.
  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_n_i) !(push_i && full_i));
  // At most two reads can be between issue and FIFO push.
  a_inflight_max: assert property (@(posedge clk_i) disable iff (!rst_n_i) inflight_i <= 2'd2);
endmodule

module pack_polyvec_compress_ctrl #(
  parameter int KYBER_N    = 256,
  parameter int KYBER_K    = 2,
  parameter int KYBER_Q    = 3329,
  parameter int i_Width    = 12,
  parameter int ADDR_W     = 7,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 iClk,
  input  logic                 iRst_n,
  input  logic                 iStart,
  output logic                 oBusy,
  output logic                 oDone,
  output logic                 oMemRd,
  output logic [ADDR_W-1:0]    oMemAddr,
  input  logic [4*i_Width-1:0] iMemData,
  output logic [39:0]          oData,
  output logic                 oValid,
  input  logic                 iReady
);
  localparam int G    = KYBER_K * KYBER_N / 4;
  localparam int CW   = ADDR_W + 1;
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int FCW  = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0]  G_C     = CW'(G);
  localparam logic [FCW-1:0] DEPTH_C = FCW'(FIFO_DEPTH);
  localparam logic [FCW:0]   CREDIT_C = (FCW + 1)'(FIFO_DEPTH);
  // (4095 << 10) + 1664 exceeds 22 bits, so the dividend carries one extra bit
  // to keep the quotient exact over the whole 12-bit input range.
  localparam logic [22:0]    HALF_Q  = 23'(KYBER_Q / 2);
  localparam logic [22:0]    Q_C     = 23'(KYBER_Q);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   rd_cnt_q, rd_cnt_d;
  logic [CW-1:0]   acc_cnt_q, acc_cnt_d;
  logic [1:0]      inflight_q, inflight_d;
  logic            rd_pend_q;
  logic            s2_v_q;
  logic [39:0]     s2_word_q;
  logic [39:0]     fifo_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [FCW-1:0]  fifo_cnt_q, fifo_cnt_d;
  logic [FCW:0]    credit_s;
  logic            rd_issue_s;
  logic            push_s;
  logic            pop_s;
  logic [39:0]     packed_s;

  function automatic logic [9:0] compress10(input logic [i_Width-1:0] x);
    logic [22:0] n;
    logic [22:0] q;
    n = (23'(x) << 10) + HALF_Q;
    q = n / Q_C;
    return q[9:0];
  endfunction

  assign credit_s   = {1'b0, fifo_cnt_q} + (FCW + 1)'(inflight_q);
  assign rd_issue_s = (state_q == ST_RUN) && (rd_cnt_q != G_C) && (credit_s < CREDIT_C);
  assign push_s     = s2_v_q;
  assign pop_s      = oValid && iReady;

  assign packed_s = {compress10(iMemData[3*i_Width +: i_Width]),
                     compress10(iMemData[2*i_Width +: i_Width]),
                     compress10(iMemData[1*i_Width +: i_Width]),
                     compress10(iMemData[0*i_Width +: i_Width])};

  assign oBusy    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign oDone    = (state_q == ST_DONE);
  assign oMemRd   = rd_issue_s;
  assign oMemAddr = rd_cnt_q[ADDR_W-1:0];
  assign oValid   = (fifo_cnt_q != '0);
  assign oData    = oValid ? fifo_q[rd_ptr_q] : 40'h0;

  // Next state and counters; DRAIN looks at the post-transfer count so oDone
  // lands in the cycle right after the last transfer.
  always_comb begin
    state_d = state_q;
    if (rd_issue_s) rd_cnt_d = rd_cnt_q + CW'(1);
    else            rd_cnt_d = rd_cnt_q;
    if (pop_s) acc_cnt_d = acc_cnt_q + CW'(1);
    else       acc_cnt_d = acc_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (iStart) begin
          state_d   = ST_RUN;
          rd_cnt_d  = '0;
          acc_cnt_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (rd_cnt_q == G_C) state_d = ST_DRAIN;
        else                 state_d = ST_RUN;
      end
      ST_DRAIN: begin
        if (acc_cnt_d == G_C) state_d = ST_DONE;
        else                  state_d = ST_DRAIN;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Reads issued but not yet pushed into the FIFO.
  always_comb begin
    case ({rd_issue_s, push_s})
      2'b10:   inflight_d = inflight_q + 2'd1;
      2'b01:   inflight_d = inflight_q - 2'd1;
      default: inflight_d = inflight_q;
    endcase
  end

  // FIFO occupancy; simultaneous push and pop cancel.
  always_comb begin
    case ({push_s, pop_s})
      2'b10:   fifo_cnt_d = fifo_cnt_q + FCW'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - FCW'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // Control state, counters and read credit.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q    <= ST_IDLE;
      rd_cnt_q   <= '0;
      acc_cnt_q  <= '0;
      inflight_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      rd_cnt_q   <= rd_cnt_d;
      acc_cnt_q  <= acc_cnt_d;
      inflight_q <= inflight_d;
    end
  end

  // Datapath: memory data returns the cycle after the read, compressed word
  // is registered at the end of that cycle.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      rd_pend_q <= 1'b0;
      s2_v_q    <= 1'b0;
      s2_word_q <= 40'h0;
    end else begin
      rd_pend_q <= rd_issue_s;
      s2_v_q    <= rd_pend_q;
      if (rd_pend_q) s2_word_q <= packed_s;
      else           s2_word_q <= s2_word_q;
    end
  end

  // Output FIFO storage and pointers; power-of-two depth lets pointers wrap.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= 40'h0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push_s) begin
        fifo_q[wr_ptr_q] <= s2_word_q;
        wr_ptr_q         <= wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_q <= wr_ptr_q;
      end
      if (pop_s) rd_ptr_q <= rd_ptr_q + PW'(1);
      else       rd_ptr_q <= rd_ptr_q;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  pack_polyvec_compress_ctrl_chk u_chk (
    .clk_i      (iClk),
    .rst_n_i    (iRst_n),
    .push_i     (push_s),
    .full_i     (fifo_cnt_q == DEPTH_C),
    .inflight_i (inflight_q)
  );
endmodule

// File: tb/tb_pack_polyvec_compress_ctrl.sv
// Scoreboard bench for pack_polyvec_compress_ctrl: a memory model serves reads,
// expected words are queued per run from an arithmetic compress model, and a
// monitor pops and compares on every transfer.
module tb_pack_polyvec_compress_ctrl;
  localparam int G = 128;

  logic        iClk = 1'b0;
  logic        iRst_n = 1'b0;
  logic        iStart = 1'b0;
  logic        oBusy, oDone, oMemRd, oValid;
  logic [6:0]  oMemAddr;
  logic [47:0] iMemData = 48'h0;
  logic [39:0] oData;
  logic        iReady = 1'b0;

  pack_polyvec_compress_ctrl dut (
    .iClk(iClk), .iRst_n(iRst_n), .iStart(iStart), .oBusy(oBusy), .oDone(oDone),
    .oMemRd(oMemRd), .oMemAddr(oMemAddr), .iMemData(iMemData), .oData(oData),
    .oValid(oValid), .iReady(iReady)
  );

  always #5 iClk = ~iClk;

  int cyc = 0;
  always @(posedge iClk) cyc <= cyc + 1;

  logic [47:0] mem [0:G-1];
  logic [39:0] exp_q [$];
  int checks = 0, errors = 0;
  int ready_pct = 100;
  int reads = 0, xfers = 0, done_cnt = 0, done_cyc = 0, last_xfer_cyc = 0, first_valid_cyc = -1;
  bit rd_seen = 1'b0;
  logic [6:0] rd_addr = 7'd0;
  bit stall_prev = 1'b0;
  logic [39:0] stall_data = 40'h0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [39:0] model_word(input logic [47:0] w);
    logic [39:0] r;
    int x, c;
    r = 40'h0;
    for (int i = 0; i < 4; i++) begin
      x = int'(w[12*i +: 12]);
      c = ((x * 1024 + 1664) / 3329) % 1024;
      r = r | (40'(c) << (10 * i));
    end
    return r;
  endfunction

  task automatic push_model(input int from_g);
    for (int g = from_g; g < G; g++) exp_q.push_back(model_word(mem[g]));
  endtask

  task automatic fill_random();
    logic [63:0] t;
    for (int g = 0; g < G; g++) begin
      t = {$urandom(), $urandom()};
      mem[g] = t[47:0];
    end
  endtask

  // Memory and sink driver: data for a read seen last cycle, garbage otherwise.
  initial begin
    logic [63:0] garbage;
    forever begin
      @(posedge iClk);
      #1;
      iReady = (ready_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < ready_pct);
      garbage = {$urandom(), $urandom()};
      iMemData = rd_seen ? mem[rd_addr] : garbage[47:0];
    end
  end

  // Monitor: credit/address checks on reads, scoreboard compare on transfers.
  always @(negedge iClk) begin
    if (iRst_n) begin
      rd_seen = oMemRd;
      rd_addr = oMemAddr;
      if (oMemRd) begin
        check("read_credit", 64'((reads - xfers) < 4), 64'd1);
        check("read_addr", 64'(oMemAddr), 64'(reads));
        reads++;
      end
      if (stall_prev) begin
        check("stall_valid", 64'(oValid), 64'd1);
        check("stall_data", 64'(oData), 64'(stall_data));
      end
      stall_prev = oValid && !iReady;
      stall_data = oData;
      if (oValid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (oValid && iReady) begin
        if (exp_q.size() == 0) check("unexpected_word", 64'(oData), 64'hDEAD);
        else check("word", 64'(oData), 64'(exp_q.pop_front()));
        xfers++;
        last_xfer_cyc = cyc;
      end
      if (oDone) begin
        done_cnt++;
        done_cyc = cyc;
        check("done_after_last_xfer", 64'(cyc), 64'(last_xfer_cyc + 1));
        check("busy_low_at_done", 64'(oBusy), 64'd0);
      end
    end else begin
      rd_seen = 1'b0;
      stall_prev = 1'b0;
    end
  end

  task automatic check_reset_outputs();
    check("rst_busy", 64'(oBusy), 64'd0);
    check("rst_done", 64'(oDone), 64'd0);
    check("rst_memrd", 64'(oMemRd), 64'd0);
    check("rst_addr", 64'(oMemAddr), 64'd0);
    check("rst_valid", 64'(oValid), 64'd0);
    check("rst_data", 64'(oData), 64'd0);
  endtask

  // One run; abort_at > 0 asserts reset once that many words were accepted.
  task automatic run_words(input bit repulse, input int abort_at);
    int start_cyc, n;
    reads = 0; xfers = 0; done_cnt = 0; first_valid_cyc = -1;
    @(posedge iClk); #1;
    iStart = 1'b1;
    start_cyc = cyc;
    @(posedge iClk); #1;
    iStart = 1'b0;
    check("busy_t1", 64'(oBusy), 64'd1);
    check("memrd_t1", 64'(oMemRd), 64'd1);
    n = 0;
    while (done_cnt == 0 && n < 3000 && !(abort_at > 0 && xfers >= abort_at)) begin
      @(posedge iClk); #1;
      n++;
      iStart = (repulse && (n == 20 || n == 90)) ? 1'b1 : 1'b0;
    end
    iStart = 1'b0;
    if (abort_at > 0) begin
      check("abort_reached", 64'(xfers >= abort_at), 64'd1);
      iRst_n = 1'b0;
      #1;
      check_reset_outputs();
      exp_q.delete();
      repeat (2) @(posedge iClk);
      #1 iRst_n = 1'b1;
    end else begin
      check("done_seen", 64'(done_cnt), 64'd1);
      check("first_valid_latency", 64'(first_valid_cyc - start_cyc), 64'd4);
      if (ready_pct >= 100 && !repulse)
        check("start_to_done", 64'(done_cyc - start_cyc), 64'd132);
      repeat (4) @(posedge iClk);
      #1;
      check("done_single_pulse", 64'(done_cnt), 64'd1);
      check("word_count", 64'(xfers), 64'(G));
      check("queue_empty", 64'(exp_q.size()), 64'd0);
      check("idle_busy", 64'(oBusy), 64'd0);
    end
  endtask

  initial begin
    repeat (3) @(posedge iClk);
    #1;
    check_reset_outputs();
    iRst_n = 1'b1;

    // Continuous sink with all-zero coefficients.
    ready_pct = 100;
    for (int g = 0; g < G; g++) mem[g] = 48'h0;
    push_model(0);
    run_words(1'b0, 0);

    // Directed values: {1665,2,1,0} and 3328 wrapping to zero.
    fill_random();
    mem[0] = {12'd1665, 12'd2, 12'd1, 12'd0};
    mem[1] = {12'd3328, 12'd3328, 12'd3328, 12'd3328};
    exp_q.push_back(40'h8000100000);
    exp_q.push_back(40'h0);
    push_model(2);
    run_words(1'b0, 0);

    // Every 12-bit input value, alternating continuous sink and backpressure.
    for (int r = 0; r < 8; r++) begin
      ready_pct = (r % 2 == 1) ? 30 : 100;
      for (int g = 0; g < G; g++)
        for (int i = 0; i < 4; i++)
          mem[g][12*i +: 12] = 12'((r * 512 + g * 4 + i) % 4096);
      push_model(0);
      run_words(1'b0, 0);
    end

    // iStart re-pulsed mid-run under backpressure.
    ready_pct = 30;
    fill_random();
    push_model(0);
    run_words(1'b1, 0);

    // Reset at word 60, then a fresh run from address 0.
    ready_pct = 100;
    fill_random();
    push_model(0);
    run_words(1'b0, 60);
    fill_random();
    push_model(0);
    run_words(1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
